// File: rtl/tinyqv_mem_arbiter.sv
// Memory arbiter between the TinyQV instruction prefetcher and its data port.
// A single streaming-read controller is shared; data accesses always win.
module tinyqv_mem_arbiter #(
    parameter int ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [23:1]          instr_addr,
    input  logic                 instr_fetch_restart,
    input  logic                 instr_fetch_stall,
    output logic                 instr_fetch_started,
    output logic                 instr_fetch_stopped,
    output logic [15:0]          instr_data_in,
    output logic                 instr_ready,

    input  logic [27:0]          data_addr,
    input  logic [1:0]           data_write_n,
    input  logic [1:0]           data_read_n,
    input  logic [31:0]          data_out,
    input  logic                 data_continue,
    output logic                 data_ready,
    output logic [31:0]          data_in,

    output logic                 ctrl_start,
    output logic                 ctrl_stop,
    output logic [ADDR_BITS-1:0] ctrl_addr,
    output logic                 ctrl_write,
    output logic [1:0]           ctrl_size,
    output logic [31:0]          ctrl_wdata,
    input  logic                 ctrl_busy,
    input  logic                 ctrl_rvalid,
    input  logic [15:0]          ctrl_rdata,
    input  logic                 ctrl_done
);

    typedef enum logic [2:0] {IDLE, INSTR, STOP, DRD, DWR} state_t;

    state_t                 state_reg;
    logic                   ctrl_start_reg;
    logic                   ctrl_stop_reg;
    logic [ADDR_BITS-1:0]   ctrl_addr_reg;
    logic                   ctrl_write_reg;
    logic [1:0]             ctrl_size_reg;
    logic [31:0]            ctrl_wdata_reg;
    logic                   started_reg;
    logic                   stopped_reg;
    logic                   data_ready_reg;
    logic [31:0]            data_in_reg;
    logic                   half_reg;

    logic data_req;
    logic fetch_break;

    assign data_req    = (data_read_n != 2'b11) || (data_write_n != 2'b11);
    assign fetch_break = data_req || instr_fetch_stall || instr_fetch_restart;

    // Data accesses are independent transactions and only the low address bits reach memory.
    logic unused_ok;
    assign unused_ok = &{1'b0, data_continue, data_addr[27:ADDR_BITS]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            ctrl_start_reg <= 1'b0;
            ctrl_stop_reg  <= 1'b0;
            ctrl_addr_reg  <= '0;
            ctrl_write_reg <= 1'b0;
            ctrl_size_reg  <= 2'b11;
            ctrl_wdata_reg <= '0;
            started_reg    <= 1'b0;
            stopped_reg    <= 1'b0;
            data_ready_reg <= 1'b0;
            data_in_reg    <= '0;
            half_reg       <= 1'b0;
        end else begin
            ctrl_start_reg <= 1'b0;
            started_reg    <= 1'b0;
            stopped_reg    <= 1'b0;
            data_ready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // The cycle showing data_ready is a bubble, so a request the CPU
                    // has not yet released is not mistaken for a new one.
                    if (!ctrl_busy && !data_ready_reg) begin
                        if (data_write_n != 2'b11) begin
                            ctrl_start_reg <= 1'b1;
                            ctrl_addr_reg  <= data_addr[ADDR_BITS-1:0];
                            ctrl_size_reg  <= data_write_n;
                            ctrl_write_reg <= 1'b1;
                            ctrl_wdata_reg <= data_out;
                            state_reg      <= DWR;
                        end else if (data_read_n != 2'b11) begin
                            ctrl_start_reg <= 1'b1;
                            ctrl_addr_reg  <= data_addr[ADDR_BITS-1:0];
                            ctrl_size_reg  <= data_read_n;
                            ctrl_write_reg <= 1'b0;
                            data_in_reg    <= '0;
                            half_reg       <= 1'b0;
                            state_reg      <= DRD;
                        end else if (instr_fetch_restart && !instr_fetch_stall) begin
                            ctrl_start_reg <= 1'b1;
                            ctrl_addr_reg  <= {instr_addr[ADDR_BITS-1:1], 1'b0};
                            ctrl_size_reg  <= 2'b11;
                            ctrl_write_reg <= 1'b0;
                            started_reg    <= 1'b1;
                            state_reg      <= INSTR;
                        end
                    end
                end
                INSTR: begin
                    if (fetch_break) begin
                        ctrl_stop_reg <= 1'b1;
                        state_reg     <= STOP;
                    end
                end
                STOP: begin
                    if (!ctrl_busy) begin
                        ctrl_stop_reg <= 1'b0;
                        stopped_reg   <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                DRD: begin
                    if (ctrl_rvalid) begin
                        if (!half_reg) begin
                            data_in_reg[15:0] <= (ctrl_size_reg == 2'b00) ?
                                                 {8'h00, ctrl_rdata[7:0]} : ctrl_rdata;
                            if (ctrl_size_reg == 2'b10) begin
                                half_reg <= 1'b1;
                            end else begin
                                data_ready_reg <= 1'b1;
                                state_reg      <= IDLE;
                            end
                        end else begin
                            data_in_reg[31:16] <= ctrl_rdata;
                            data_ready_reg     <= 1'b1;
                            state_reg          <= IDLE;
                        end
                    end
                end
                DWR: begin
                    if (ctrl_done) begin
                        data_ready_reg <= 1'b1;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Halfwords are forwarded combinationally, but never in a cycle that ends the stream.
    assign instr_ready         = !rst && (state_reg == INSTR) && ctrl_rvalid && !fetch_break;
    assign instr_data_in       = ctrl_rdata;
    assign instr_fetch_started = started_reg;
    assign instr_fetch_stopped = stopped_reg;
    assign data_ready          = data_ready_reg;
    assign data_in             = data_in_reg;
    assign ctrl_start          = ctrl_start_reg;
    assign ctrl_stop           = ctrl_stop_reg;
    assign ctrl_addr           = ctrl_addr_reg;
    assign ctrl_write          = ctrl_write_reg;
    assign ctrl_size           = ctrl_size_reg;
    assign ctrl_wdata          = ctrl_wdata_reg;

endmodule

// File: tb/tb_tinyqv_mem_arbiter.sv
// Directed bench for tinyqv_mem_arbiter; the bench itself plays the memory controller.
module tb_tinyqv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:1] instr_addr;
    logic        instr_fetch_restart, instr_fetch_stall;
    logic        instr_fetch_started, instr_fetch_stopped;
    logic [15:0] instr_data_in;
    logic        instr_ready;
    logic [27:0] data_addr;
    logic [1:0]  data_write_n, data_read_n;
    logic [31:0] data_out;
    logic        data_continue;
    logic        data_ready;
    logic [31:0] data_in;
    logic        ctrl_start, ctrl_stop;
    logic [23:0] ctrl_addr;
    logic        ctrl_write;
    logic [1:0]  ctrl_size;
    logic [31:0] ctrl_wdata;
    logic        ctrl_busy, ctrl_rvalid, ctrl_done;
    logic [15:0] ctrl_rdata;

    int n_cmp = 0;
    int n_err = 0;

    tinyqv_mem_arbiter #(.ADDR_BITS(24)) dut (
        .clk(clk), .rst(rst),
        .instr_addr(instr_addr),
        .instr_fetch_restart(instr_fetch_restart),
        .instr_fetch_stall(instr_fetch_stall),
        .instr_fetch_started(instr_fetch_started),
        .instr_fetch_stopped(instr_fetch_stopped),
        .instr_data_in(instr_data_in),
        .instr_ready(instr_ready),
        .data_addr(data_addr),
        .data_write_n(data_write_n),
        .data_read_n(data_read_n),
        .data_out(data_out),
        .data_continue(data_continue),
        .data_ready(data_ready),
        .data_in(data_in),
        .ctrl_start(ctrl_start),
        .ctrl_stop(ctrl_stop),
        .ctrl_addr(ctrl_addr),
        .ctrl_write(ctrl_write),
        .ctrl_size(ctrl_size),
        .ctrl_wdata(ctrl_wdata),
        .ctrl_busy(ctrl_busy),
        .ctrl_rvalid(ctrl_rvalid),
        .ctrl_rdata(ctrl_rdata),
        .ctrl_done(ctrl_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-22s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        instr_addr = '0; instr_fetch_restart = 1'b0; instr_fetch_stall = 1'b0;
        data_addr = '0; data_write_n = 2'b11; data_read_n = 2'b11;
        data_out = '0; data_continue = 1'b0;
        ctrl_busy = 1'b0; ctrl_rvalid = 1'b0; ctrl_rdata = '0; ctrl_done = 1'b0;
        tick(); tick();
        chk("rst_size", {30'd0, ctrl_size}, 32'd3);
        chk("rst_start", {31'd0, ctrl_start}, 32'd0);
        chk("rst_stop", {31'd0, ctrl_stop}, 32'd0);
        chk("rst_data_in", data_in, 32'd0);
        chk("rst_ready", {31'd0, data_ready}, 32'd0);
        rst = 1'b0;

        // Instruction stream from 0x100 halfwords -> byte 0x200
        instr_addr = 23'h000100; instr_fetch_restart = 1'b1;
        tick();
        chk("if_start", {31'd0, ctrl_start}, 32'd1);
        chk("if_started", {31'd0, instr_fetch_started}, 32'd1);
        chk("if_addr", {8'd0, ctrl_addr}, 32'h000200);
        chk("if_size", {30'd0, ctrl_size}, 32'd3);
        chk("if_write", {31'd0, ctrl_write}, 32'd0);
        instr_fetch_restart = 1'b0; ctrl_busy = 1'b1;
        tick();
        chk("if_start_pulse", {31'd0, ctrl_start}, 32'd0);
        ctrl_rvalid = 1'b1; ctrl_rdata = 16'h1234; #1;
        chk("if_rdy0", {31'd0, instr_ready}, 32'd1);
        chk("if_dat0", {16'd0, instr_data_in}, 32'h1234);
        tick();
        ctrl_rdata = 16'h5678; #1;
        chk("if_rdy1", {31'd0, instr_ready}, 32'd1);
        chk("if_dat1", {16'd0, instr_data_in}, 32'h5678);
        tick();
        ctrl_rvalid = 1'b0; #1;
        chk("if_rdy_idle", {31'd0, instr_ready}, 32'd0);

        // 32-bit read interrupting the stream
        data_read_n = 2'b10; data_addr = 28'h0000040;
        tick();
        chk("dr_stop", {31'd0, ctrl_stop}, 32'd1);
        ctrl_rvalid = 1'b1; ctrl_rdata = 16'h9999; #1;
        chk("dr_stop_drop", {31'd0, instr_ready}, 32'd0);
        tick();
        chk("dr_stop_hold", {31'd0, ctrl_stop}, 32'd1);
        chk("dr_no_stopped", {31'd0, instr_fetch_stopped}, 32'd0);
        ctrl_rvalid = 1'b0; ctrl_busy = 1'b0;
        tick();
        chk("dr_stopped", {31'd0, instr_fetch_stopped}, 32'd1);
        chk("dr_stop_low", {31'd0, ctrl_stop}, 32'd0);
        chk("dr_no_start", {31'd0, ctrl_start}, 32'd0);
        tick();
        chk("dr_start", {31'd0, ctrl_start}, 32'd1);
        chk("dr_addr", {8'd0, ctrl_addr}, 32'h000040);
        chk("dr_size", {30'd0, ctrl_size}, 32'd2);
        chk("dr_write", {31'd0, ctrl_write}, 32'd0);
        ctrl_busy = 1'b1;
        tick();
        ctrl_rvalid = 1'b1; ctrl_rdata = 16'hBEEF;
        tick();
        chk("dr_ready_early", {31'd0, data_ready}, 32'd0);
        ctrl_rdata = 16'hDEAD;
        tick();
        chk("dr_ready", {31'd0, data_ready}, 32'd1);
        chk("dr_data", data_in, 32'hDEADBEEF);
        data_read_n = 2'b11; ctrl_rvalid = 1'b0; ctrl_busy = 1'b0;
        tick();
        chk("dr_ready_pulse", {31'd0, data_ready}, 32'd0);
        chk("dr_no_restart", {31'd0, ctrl_start}, 32'd0);

        // 8-bit write; request deliberately held one cycle past data_ready
        data_write_n = 2'b00; data_out = 32'h000000A5; data_addr = 28'h0000003;
        tick();
        chk("wr_start", {31'd0, ctrl_start}, 32'd1);
        chk("wr_write", {31'd0, ctrl_write}, 32'd1);
        chk("wr_size", {30'd0, ctrl_size}, 32'd0);
        chk("wr_wdata", ctrl_wdata, 32'h000000A5);
        chk("wr_addr", {8'd0, ctrl_addr}, 32'h000003);
        data_out = 32'hFFFFFFFF; ctrl_busy = 1'b1;
        tick();
        chk("wr_wdata_hold", ctrl_wdata, 32'h000000A5);
        chk("wr_ready_early", {31'd0, data_ready}, 32'd0);
        ctrl_done = 1'b1;
        tick();
        chk("wr_ready", {31'd0, data_ready}, 32'd1);
        ctrl_done = 1'b0; ctrl_busy = 1'b0;
        tick();
        chk("wr_bubble", {31'd0, ctrl_start}, 32'd0);
        data_write_n = 2'b11;
        tick();
        chk("wr_idle", {31'd0, ctrl_start}, 32'd0);

        // Stall with a halfword in the same cycle
        instr_addr = 23'h000010; instr_fetch_restart = 1'b1;
        tick();
        chk("st_started", {31'd0, instr_fetch_started}, 32'd1);
        chk("st_addr", {8'd0, ctrl_addr}, 32'h000020);
        instr_fetch_restart = 1'b0; ctrl_busy = 1'b1;
        tick();
        instr_fetch_stall = 1'b1; ctrl_rvalid = 1'b1; ctrl_rdata = 16'h1111; #1;
        chk("st_no_ready", {31'd0, instr_ready}, 32'd0);
        tick();
        chk("st_stop", {31'd0, ctrl_stop}, 32'd1);
        ctrl_rvalid = 1'b0;
        tick();
        chk("st_stop_hold", {31'd0, ctrl_stop}, 32'd1);
        ctrl_busy = 1'b0;
        tick();
        chk("st_stopped", {31'd0, instr_fetch_stopped}, 32'd1);
        instr_fetch_restart = 1'b1;
        tick();
        chk("st_no_restart", {31'd0, ctrl_start}, 32'd0);
        chk("st_one_stopped", {31'd0, instr_fetch_stopped}, 32'd0);
        tick();
        chk("st_no_restart2", {31'd0, ctrl_start}, 32'd0);
        instr_fetch_restart = 1'b0; instr_fetch_stall = 1'b0;
        tick();

        // Write and read both requested: write first
        data_write_n = 2'b10; data_read_n = 2'b10;
        data_out = 32'hCAFEF00D; data_addr = 28'h0000123;
        tick();
        chk("pr_start", {31'd0, ctrl_start}, 32'd1);
        chk("pr_write", {31'd0, ctrl_write}, 32'd1);
        chk("pr_size", {30'd0, ctrl_size}, 32'd2);
        chk("pr_wdata", ctrl_wdata, 32'hCAFEF00D);
        ctrl_busy = 1'b1;
        tick();
        ctrl_done = 1'b1;
        tick();
        chk("pr_ready", {31'd0, data_ready}, 32'd1);
        data_write_n = 2'b11; data_read_n = 2'b11; ctrl_done = 1'b0; ctrl_busy = 1'b0;
        tick();

        // Reset in the middle of a 16-bit read
        data_read_n = 2'b01; data_addr = 28'h0000050;
        tick();
        chk("rr_start", {31'd0, ctrl_start}, 32'd1);
        chk("rr_size", {30'd0, ctrl_size}, 32'd1);
        ctrl_busy = 1'b1;
        tick();
        ctrl_rvalid = 1'b1; ctrl_rdata = 16'h7777; rst = 1'b1;
        tick();
        chk("rr_no_ready", {31'd0, data_ready}, 32'd0);
        chk("rr_data_in", data_in, 32'd0);
        chk("rr_size_rst", {30'd0, ctrl_size}, 32'd3);
        chk("rr_stop_rst", {31'd0, ctrl_stop}, 32'd0);
        rst = 1'b0; ctrl_rvalid = 1'b0;
        tick();
        chk("rr_wait_busy", {31'd0, ctrl_start}, 32'd0);
        tick();
        chk("rr_wait_busy2", {31'd0, ctrl_start}, 32'd0);
        ctrl_busy = 1'b0;
        tick();
        chk("rr_restart", {31'd0, ctrl_start}, 32'd1);
        chk("rr_addr", {8'd0, ctrl_addr}, 32'h000050);
        ctrl_busy = 1'b1;
        tick();
        ctrl_rvalid = 1'b1; ctrl_rdata = 16'hABCD;
        tick();
        chk("rr_ready", {31'd0, data_ready}, 32'd1);
        chk("rr_data", data_in, 32'h0000ABCD);
        data_read_n = 2'b11; ctrl_rvalid = 1'b0; ctrl_busy = 1'b0;
        tick();

        // 8-bit read masks the upper byte of the halfword
        data_read_n = 2'b00; data_addr = 28'h0000007;
        tick();
        chk("b8_size", {30'd0, ctrl_size}, 32'd0);
        ctrl_busy = 1'b1;
        tick();
        ctrl_rvalid = 1'b1; ctrl_rdata = 16'h12FE;
        tick();
        chk("b8_ready", {31'd0, data_ready}, 32'd1);
        chk("b8_data", data_in, 32'h000000FE);
        data_read_n = 2'b11; ctrl_rvalid = 1'b0; ctrl_busy = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
